lc3_mem_wait_model: RTL and testbench

Parametrised multi-channel memory responder with programmable wait states for the LC3 verification environment. It replaces fixed zero-latency instruction/data memory responses with N independent request/complete channels over one shared word array. Per-channel latency is fixed, pseudo-random (LFSR) or held indefinitely, which exercises the DUT's `complete_instr`/`complete_data` stall paths. Per-channel stall and completion counters feed coverage and stall-threshold checks.

---
 rtl/lc3_mem_wait_model_if.sv | 30 +++
 rtl/lc3_mem_wait_model.sv | 120 ++++++++++++
 tb/tb_lc3_mem_wait_model.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3_mem_wait_model_if.sv
// Request/complete bundle for the LC3 memory wait-state responder.
// Channel i occupies slice i of every packed vector.
interface lc3_mem_wait_model_if #(
  parameter int NUM_CH = 2,
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int LAT_W  = 3,
  parameter int CNT_W  = 32
);
  logic [NUM_CH-1:0]       req;
  logic [NUM_CH-1:0]       rd;
  logic [NUM_CH*AW-1:0]    addr;
  logic [NUM_CH*DW-1:0]    wdata;
  logic [NUM_CH*2-1:0]     lat_mode;
  logic [NUM_CH*LAT_W-1:0] lat_cfg;
  logic [NUM_CH*DW-1:0]    rdata;
  logic [NUM_CH-1:0]       complete;
  logic [NUM_CH*CNT_W-1:0] stall_cnt;
  logic [NUM_CH*CNT_W-1:0] done_cnt;

  modport master (
    output req, rd, addr, wdata, lat_mode, lat_cfg,
    input  rdata, complete, stall_cnt, done_cnt
  );

  modport slave (
    input  req, rd, addr, wdata, lat_mode, lat_cfg,
    output rdata, complete, stall_cnt, done_cnt
  );
endinterface

// File: rtl/lc3_mem_wait_model.sv
// Multi-channel memory responder with programmable wait states.
// Channels share one word array; lowest channel wins write collisions.
module lc3_mem_wait_model #(
  parameter int              NUM_CH    = 2,
  parameter int              AW        = 16,
  parameter int              DW        = 16,
  parameter int              MEM_AW    = 12,
  parameter logic [AW-1:0]   BASE_ADDR = 16'h3000,
  parameter int              LAT_W     = 3,
  parameter logic [15:0]     SEED      = 16'hACE1,
  parameter int              CNT_W     = 32
) (
  input logic                 clock,
  input logic                 reset,
  lc3_mem_wait_model_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_e;

  localparam int         DEPTH  = 1 << MEM_AW;
  localparam logic [1:0] M_RAND = 2'd1;
  localparam logic [1:0] M_HOLD = 2'd2;

  logic [DW-1:0]     mem_q [DEPTH];
  logic [NUM_CH-1:0] we;
  logic [MEM_AW-1:0] widx [NUM_CH];
  logic [DW-1:0]     wdat [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [15:0] SD0 = SEED + 16'(i);
    localparam logic [15:0] SD  = (SD0 == 16'h0) ? 16'hACE1 : SD0;

    state_e            st_q, st_d;
    logic [LAT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       lfsr_q;
    logic [DW-1:0]     rdata_q;
    logic [CNT_W-1:0]  stall_q;
    logic [CNT_W-1:0]  done_q;
    logic [AW-1:0]     a;
    logic [1:0]        mode;
    logic [LAT_W-1:0]  cfg;
    logic [LAT_W-1:0]  lat;
    logic [MEM_AW-1:0] idx;

    assign a    = bus.addr[i*AW +: AW];
    assign mode = bus.lat_mode[i*2 +: 2];
    assign cfg  = bus.lat_cfg[i*LAT_W +: LAT_W];
    assign idx  = MEM_AW'(a - BASE_ADDR);
    assign lat  = (mode == M_RAND) ? lfsr_q[LAT_W-1:0] : cfg;

    // Next state: latency chosen at accept, hold re-evaluated each WAIT
    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      unique case (st_q)
        S_IDLE: begin
          if (bus.req[i]) begin
            if (lat == '0) begin
              st_d = S_DONE;
            end else begin
              st_d  = S_WAIT;
              cnt_d = lat - LAT_W'(1);
            end
          end
        end
        S_WAIT: begin
          if (mode != M_HOLD) begin
            if (cnt_q == '0) st_d = S_DONE;
            else cnt_d = cnt_q - LAT_W'(1);
          end
        end
        S_DONE:  st_d = S_IDLE;
        default: st_d = S_IDLE;
      endcase
    end

    // State, LFSR, read capture and saturating counters
    always_ff @(posedge clock) begin
      if (!reset) begin
        st_q    <= S_IDLE;
        cnt_q   <= '0;
        lfsr_q  <= SD;
        rdata_q <= '0;
        stall_q <= '0;
        done_q  <= '0;
      end else begin
        st_q   <= st_d;
        cnt_q  <= cnt_d;
        lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5],
                   lfsr_q[15:1]};
        if (st_d == S_DONE && st_q != S_DONE) rdata_q <= mem_q[idx];
        if (st_q == S_WAIT && stall_q != '1)
          stall_q <= stall_q + CNT_W'(1);
        if (st_q == S_DONE && done_q != '1)
          done_q <= done_q + CNT_W'(1);
      end
    end

    assign we[i]   = (st_q == S_DONE) && !bus.rd[i];
    assign widx[i] = idx;
    assign wdat[i] = bus.wdata[i*DW +: DW];

    assign bus.complete[i]                = (st_q == S_DONE);
    assign bus.rdata[i*DW +: DW]          = rdata_q;
    assign bus.stall_cnt[i*CNT_W +: CNT_W] = stall_q;
    assign bus.done_cnt[i*CNT_W +: CNT_W]  = done_q;
  end

  // Array writes leaving DONE; descending loop lets channel 0 win
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (we[i]) mem_q[widx[i]] <= wdat[i];
      end
    end
  end
endmodule

// File: tb/tb_lc3_mem_wait_model.sv
// Directed bench for the LC3 memory wait-state responder.
// Each task drives one scenario and checks against hand-derived values.
module tb_lc3_mem_wait_model;
  localparam int NUM_CH = 2;
  localparam int AW     = 16;
  localparam int DW     = 16;
  localparam int LAT_W  = 3;
  localparam int CNT_W  = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   vec   = 0;
  int   bad   = 0;

  lc3_mem_wait_model_if #(
    .NUM_CH(NUM_CH), .AW(AW), .DW(DW), .LAT_W(LAT_W), .CNT_W(CNT_W)
  ) bus ();

  lc3_mem_wait_model #(
    .NUM_CH(NUM_CH), .AW(AW), .DW(DW), .LAT_W(LAT_W), .CNT_W(CNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  logic [15:0] m_lfsr;
  logic [15:0] m_prev;

  always @(posedge clock) begin
    m_prev <= m_lfsr;
    if (!reset) m_lfsr <= 16'hACE1;
    else m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5],
                    m_lfsr[15:1]};
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic r, input logic rdn,
                        input logic [15:0] a, input logic [15:0] d,
                        input logic [1:0] m, input logic [2:0] l);
    bus.req[ch]               = r;
    bus.rd[ch]                = rdn;
    bus.addr[ch*16 +: 16]     = a;
    bus.wdata[ch*16 +: 16]    = d;
    bus.lat_mode[ch*2 +: 2]   = m;
    bus.lat_cfg[ch*3 +: 3]    = l;
  endtask

  function automatic logic [15:0] rdat(input int ch);
    return bus.rdata[ch*16 +: 16];
  endfunction

  function automatic logic [31:0] stl(input int ch);
    return bus.stall_cnt[ch*32 +: 32];
  endfunction

  function automatic logic [31:0] dn(input int ch);
    return bus.done_cnt[ch*32 +: 32];
  endfunction

  task automatic test_reset();
    repeat (3) tick();
    vec++;
    if (bus.complete !== 2'b00) begin
      bad++;
      $display("FAIL rst_complete got %b want 00", bus.complete);
    end
    vec++;
    if (bus.stall_cnt !== '0) begin
      bad++;
      $display("FAIL rst_stall got %h want 0", bus.stall_cnt);
    end
    vec++;
    if (bus.done_cnt !== '0) begin
      bad++;
      $display("FAIL rst_done got %h want 0", bus.done_cnt);
    end
    vec++;
    if (bus.rdata !== '0) begin
      bad++;
      $display("FAIL rst_rdata got %h want 0", bus.rdata);
    end
    reset = 1'b1;
  endtask

  task automatic test_fixed_l0();
    set_ch(1, 1'b1, 1'b0, 16'h3004, 16'hBEEF, 2'd0, 3'd0);
    tick();
    vec++;
    if (bus.complete[1] !== 1'b1) begin
      bad++;
      $display("FAIL l0_wr_cpl got %b want 1", bus.complete[1]);
    end
    bus.req[1] = 1'b0;
    tick();
    vec++;
    if (bus.complete[1] !== 1'b0) begin
      bad++;
      $display("FAIL l0_wr_one got %b want 0", bus.complete[1]);
    end
    set_ch(0, 1'b1, 1'b1, 16'h3004, 16'h0000, 2'd0, 3'd0);
    tick();
    vec++;
    if (bus.complete[0] !== 1'b1) begin
      bad++;
      $display("FAIL l0_rd_cpl got %b want 1", bus.complete[0]);
    end
    vec++;
    if (rdat(0) !== 16'hBEEF) begin
      bad++;
      $display("FAIL l0_rd_data got %h want beef", rdat(0));
    end
    bus.req[0] = 1'b0;
    tick();
    vec++;
    if (dn(0) !== 32'd1) begin
      bad++;
      $display("FAIL l0_done0 got %0d want 1", dn(0));
    end
    vec++;
    if (dn(1) !== 32'd1) begin
      bad++;
      $display("FAIL l0_done1 got %0d want 1", dn(1));
    end
  endtask

  task automatic test_fixed_l5();
    int k;
    set_ch(0, 1'b1, 1'b1, 16'h3004, 16'h0000, 2'd0, 3'd5);
    tick();
    k = 0;
    while (!bus.complete[0] && k < 20) begin
      tick();
      k++;
    end
    vec++;
    if (k !== 5) begin
      bad++;
      $display("FAIL l5_latency got %0d want 5", k);
    end
    vec++;
    if (stl(0) !== 32'd5) begin
      bad++;
      $display("FAIL l5_stall got %0d want 5", stl(0));
    end
    vec++;
    if (rdat(0) !== 16'hBEEF) begin
      bad++;
      $display("FAIL l5_data got %h want beef", rdat(0));
    end
    tick();
    vec++;
    if (bus.complete[0] !== 1'b0) begin
      bad++;
      $display("FAIL l5_one_cycle got %b want 0", bus.complete[0]);
    end
    tick();
    vec++;
    if (stl(0) !== 32'd5) begin
      bad++;
      $display("FAIL l5_bubble got %0d want 5", stl(0));
    end
    tick();
    vec++;
    if (stl(0) !== 32'd6) begin
      bad++;
      $display("FAIL l5_reaccept got %0d want 6", stl(0));
    end
    bus.req[0] = 1'b0;
    k = 0;
    while (!bus.complete[0] && k < 20) begin
      tick();
      k++;
    end
    vec++;
    if (k !== 4) begin
      bad++;
      $display("FAIL l5_second got %0d want 4", k);
    end
    tick();
  endtask

  task automatic test_hold();
    logic [31:0] s0;
    int          seen;
    s0 = stl(0);
    set_ch(0, 1'b1, 1'b1, 16'h3004, 16'h0000, 2'd2, 3'd2);
    tick();
    bus.req[0] = 1'b0;
    seen = 0;
    for (int n = 0; n < 1000; n++) begin
      tick();
      if (bus.complete[0]) seen++;
    end
    vec++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL hold_no_cpl got %0d want 0", seen);
    end
    bus.lat_mode[1:0] = 2'd0;
    bus.lat_cfg[2:0]  = 3'd0;
    tick();
    vec++;
    if (bus.complete[0] !== 1'b0) begin
      bad++;
      $display("FAIL hold_rel1 got %b want 0", bus.complete[0]);
    end
    tick();
    vec++;
    if (bus.complete[0] !== 1'b1) begin
      bad++;
      $display("FAIL hold_rel2 got %b want 1", bus.complete[0]);
    end
    vec++;
    if (stl(0) - s0 !== 32'd1002) begin
      bad++;
      $display("FAIL hold_stall got %0d want 1002", stl(0) - s0);
    end
    tick();
  endtask

  task automatic test_collision();
    set_ch(0, 1'b1, 1'b0, 16'h3010, 16'h1111, 2'd0, 3'd0);
    set_ch(1, 1'b1, 1'b0, 16'h3010, 16'h2222, 2'd0, 3'd0);
    tick();
    vec++;
    if (bus.complete !== 2'b11) begin
      bad++;
      $display("FAIL coll_cpl got %b want 11", bus.complete);
    end
    bus.req = 2'b00;
    tick();
    set_ch(1, 1'b1, 1'b1, 16'h3010, 16'h0000, 2'd0, 3'd0);
    tick();
    vec++;
    if (rdat(1) !== 16'h1111) begin
      bad++;
      $display("FAIL coll_winner got %h want 1111", rdat(1));
    end
    bus.req[1] = 1'b0;
    tick();
    set_ch(0, 1'b1, 1'b0, 16'h3010, 16'h3333, 2'd0, 3'd0);
    set_ch(1, 1'b1, 1'b1, 16'h3010, 16'h0000, 2'd0, 3'd1);
    tick();
    bus.req = 2'b00;
    tick();
    vec++;
    if (bus.complete[1] !== 1'b1 || rdat(1) !== 16'h1111) begin
      bad++;
      $display("FAIL coll_old got %b/%h want 1/1111",
               bus.complete[1], rdat(1));
    end
    tick();
    set_ch(1, 1'b1, 1'b1, 16'h3010, 16'h0000, 2'd0, 3'd0);
    tick();
    vec++;
    if (rdat(1) !== 16'h3333) begin
      bad++;
      $display("FAIL coll_new got %h want 3333", rdat(1));
    end
    bus.req[1] = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [7:0] hit;
    int         k;
    int         e;
    hit = '0;
    for (int n = 0; n < 1000; n++) begin
      set_ch(0, 1'b1, 1'b1, 16'h3004, 16'h0000, 2'd1, 3'd0);
      tick();
      e = int'(m_prev[2:0]);
      k = 0;
      while (!bus.complete[0] && k < 20) begin
        tick();
        k++;
      end
      vec++;
      if (k !== e) begin
        bad++;
        $display("FAIL rand_lat[%0d] got %0d want %0d", n, k, e);
      end
      if (k < 8) hit[k] = 1'b1;
      bus.req[0] = 1'b0;
      tick();
    end
    vec++;
    if (hit !== 8'hFF) begin
      bad++;
      $display("FAIL rand_cover got %b want 11111111", hit);
    end
  endtask

  task automatic test_reset_abort();
    int seen;
    set_ch(1, 1'b1, 1'b0, 16'h3020, 16'h0001, 2'd0, 3'd0);
    tick();
    bus.req[1] = 1'b0;
    tick();
    set_ch(0, 1'b1, 1'b0, 16'h3020, 16'hDEAD, 2'd0, 3'd4);
    tick();
    tick();
    tick();
    reset = 1'b0;
    bus.req[0] = 1'b0;
    tick();
    reset = 1'b1;
    vec++;
    if (bus.complete !== 2'b00) begin
      bad++;
      $display("FAIL abort_cpl got %b want 00", bus.complete);
    end
    vec++;
    if (bus.stall_cnt !== '0 || bus.done_cnt !== '0) begin
      bad++;
      $display("FAIL abort_cnt got %h/%h want 0/0",
               bus.stall_cnt, bus.done_cnt);
    end
    seen = 0;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (bus.complete[0]) seen++;
    end
    vec++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL abort_late_cpl got %0d want 0", seen);
    end
    set_ch(0, 1'b1, 1'b1, 16'h3020, 16'h0000, 2'd0, 3'd0);
    tick();
    vec++;
    if (rdat(0) !== 16'h0001) begin
      bad++;
      $display("FAIL abort_data got %h want 0001", rdat(0));
    end
    bus.req[0] = 1'b0;
    tick();
  endtask

  initial begin
    bus.req      = '0;
    bus.rd       = '0;
    bus.addr     = '0;
    bus.wdata    = '0;
    bus.lat_mode = '0;
    bus.lat_cfg  = '0;
    test_reset();
    test_fixed_l0();
    test_fixed_l5();
    test_hold();
    test_collision();
    test_random();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
